// File: rtl/neurochip_pkg.sv
// Shared constants and helpers for the neurochip display datapath.
// Imported by the timebase, its digit counter and the bus interface.
package neurochip_pkg;

    localparam int               CNT_W          = 24;
    localparam int               DIGIT_W        = 4;
    localparam logic [3:0]       DIGIT_MAX      = 4'd9;
    localparam logic [CNT_W-1:0] DEFAULT_PERIOD = 24'd10_000_000;

    // A zero request means "use the built-in period", so the switches never select an empty period.
    function automatic logic [CNT_W-1:0] select_period(input logic [CNT_W-1:0] req,
                                                       input logic [CNT_W-1:0] dflt);
        return (req == '0) ? dflt : req;
    endfunction

endpackage

// File: rtl/digit_timebase_if.sv
// Control and status bundle between the top-level selection logic and the digit timebase.
// The master drives the controls; the slave (the timebase) returns tick, wrap, digit and debug count.
interface digit_timebase_if;
    import neurochip_pkg::*;

    logic               ena;
    logic               run;
    logic               clear;
    logic [CNT_W-1:0]   compare_in;
    logic               tick;
    logic               wrap;
    logic [DIGIT_W-1:0] digit;
    logic [7:0]         cnt_lsb;

    modport master (
        output ena, run, clear, compare_in,
        input  tick, wrap, digit, cnt_lsb
    );

    modport slave (
        input  ena, run, clear, compare_in,
        output tick, wrap, digit, cnt_lsb
    );

endinterface

// File: rtl/digit_timebase_bcd.sv
// Single BCD digit 0..9 with a registered wrap pulse on the 9->0 step.
// Reusable for further display digits by chaining wrap into the next digit's en.
module bcd_digit_counter
    import neurochip_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    output logic [DIGIT_W-1:0] digit,
    output logic               wrap
);

    // Any out-of-range value falls back to 0 on the next advance rather than counting on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
            wrap  <= 1'b0;
        end else if (clr) begin
            digit <= '0;
            wrap  <= 1'b0;
        end else if (en) begin
            wrap  <= (digit == DIGIT_MAX);
            digit <= (digit >= DIGIT_MAX) ? '0 : digit + 1'b1;
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: rtl/digit_timebase.sv
// Runtime-selectable prescaler that emits a 1-cycle tick per period and steps a BCD digit.
// The period register only reloads at a period boundary or on clear, so switch changes never glitch a period.
module digit_timebase
    import neurochip_pkg::*;
#(
    parameter logic [CNT_W-1:0] MAX_COUNT = DEFAULT_PERIOD
) (
    input  logic                   clk,
    input  logic                   rst_n,
    digit_timebase_if.slave        bus
);

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cmp_q;
    logic [CNT_W-1:0]   cmp_next;
    logic               term;
    logic               tick_q;
    logic               digit_en;
    logic               digit_clr;
    logic [DIGIT_W-1:0] digit_q;
    logic               wrap_q;

    // >= keeps the counter bounded even if cmp_q were ever below the current count.
    always_comb begin
        cmp_next  = select_period(bus.compare_in, MAX_COUNT);
        term      = (cnt >= (cmp_q - CNT_W'(1)));
        digit_clr = bus.ena & bus.clear;
        digit_en  = bus.ena & ~bus.clear & bus.run & term;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            cmp_q  <= MAX_COUNT;
            tick_q <= 1'b0;
        end else if (!bus.ena) begin
            tick_q <= 1'b0;
        end else if (bus.clear) begin
            cnt    <= '0;
            cmp_q  <= cmp_next;
            tick_q <= 1'b0;
        end else if (!bus.run) begin
            tick_q <= 1'b0;
        end else if (term) begin
            cnt    <= '0;
            cmp_q  <= cmp_next;
            tick_q <= 1'b1;
        end else begin
            cnt    <= cnt + CNT_W'(1);
            tick_q <= 1'b0;
        end
    end

    bcd_digit_counter u_digit (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (digit_en),
        .clr   (digit_clr),
        .digit (digit_q),
        .wrap  (wrap_q)
    );

    assign bus.tick    = tick_q;
    assign bus.wrap    = wrap_q;
    assign bus.digit   = digit_q;
    assign bus.cnt_lsb = cnt[7:0];

endmodule

// File: tb/tb_digit_timebase.sv
// Directed bench for digit_timebase with a 5-cycle default period.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_digit_timebase;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    digit_timebase_if bus ();

    digit_timebase #(.MAX_COUNT(24'd5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Checks {tick, wrap, digit} after each of n edges: idle for n-1 edges, then the tick edge.
    task automatic test_period(input string name, input int n, input logic [3:0] exp_digit,
                               input logic exp_wrap);
        logic [5:0] exp;
        logic [5:0] act;
        for (int j = 1; j <= n; j++) begin
            run_cycles(1);
            act = {bus.tick, bus.wrap, bus.digit};
            exp = (j == n) ? {1'b1, exp_wrap, exp_digit} : {2'b00, bus.digit};
            if (j < n) exp[3:0] = (exp_digit == 4'd0) ? 4'd9 : exp_digit - 4'd1;
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("[TB] FAIL %s edge %0d: got tick/wrap/digit=%b, expected %b", name, j, act, exp);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.ena = 1'b1;
        bus.run = 1'b1;
        bus.clear = 1'b0;
        bus.compare_in = '0;
        run_cycles(2);
        n_vec++;
        if ({bus.tick, bus.wrap, bus.digit, bus.cnt_lsb} !== 14'd0) begin
            n_err++;
            $display("[TB] FAIL reset_state: got %b, expected 0", {bus.tick, bus.wrap, bus.digit, bus.cnt_lsb});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_default_period;
        for (int k = 1; k <= 10; k++)
            test_period("default_period", 5, 4'(k % 10), k == 10);
    endtask

    task automatic test_compare_change;
        run_cycles(1);
        n_vec++;
        if (bus.cnt_lsb !== 8'd1) begin
            n_err++;
            $display("[TB] FAIL cmp_change_cnt: got %0d, expected 1", bus.cnt_lsb);
        end
        bus.compare_in = 24'd3;
        test_period("cmp_change_old", 4, 4'd1, 1'b0);
        test_period("cmp_change_new", 3, 4'd2, 1'b0);
        test_period("cmp_change_new", 3, 4'd3, 1'b0);
    endtask

    task automatic test_every_cycle;
        bus.compare_in = 24'd1;
        test_period("cmp1_load", 3, 4'd4, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            test_period("cmp1_tick", 1, 4'((4 + i) % 10), ((4 + i) % 10) == 0);
            n_vec++;
            if (bus.cnt_lsb !== 8'd0) begin
                n_err++;
                $display("[TB] FAIL cmp1_cnt: got %0d, expected 0", bus.cnt_lsb);
            end
        end
    endtask

    // Freeze at cnt=2 for 7 edges using either run or ena, then expect the tick 3 edges after resume.
    task automatic test_pause(input logic use_ena, input logic [3:0] held_digit);
        run_cycles(2);
        if (use_ena) bus.ena = 1'b0; else bus.run = 1'b0;
        for (int i = 0; i < 7; i++) begin
            run_cycles(1);
            n_vec++;
            if ({bus.tick, bus.wrap, bus.digit, bus.cnt_lsb} !== {2'b00, held_digit, 8'd2}) begin
                n_err++;
                $display("[TB] FAIL pause(ena=%0b): got %b, expected %b", use_ena,
                         {bus.tick, bus.wrap, bus.digit, bus.cnt_lsb}, {2'b00, held_digit, 8'd2});
            end
        end
        bus.ena = 1'b1;
        bus.run = 1'b1;
        test_period("pause_resume", 3, held_digit + 4'd1, 1'b0);
    endtask

    task automatic test_clear_on_term;
        test_period("pre_clear", 5, 4'd8, 1'b0);
        test_period("pre_clear", 5, 4'd9, 1'b0);
        run_cycles(4);
        bus.clear = 1'b1;
        run_cycles(1);
        bus.clear = 1'b0;
        n_vec++;
        if ({bus.tick, bus.wrap, bus.digit, bus.cnt_lsb} !== 14'd0) begin
            n_err++;
            $display("[TB] FAIL clear_on_term: got %b, expected 0", {bus.tick, bus.wrap, bus.digit, bus.cnt_lsb});
        end
        test_period("post_clear", 5, 4'd1, 1'b0);
    endtask

    task automatic test_async_reset;
        bus.compare_in = 24'd3;
        test_period("pre_reset", 5, 4'd2, 1'b0);
        test_period("pre_reset", 3, 4'd3, 1'b0);
        test_period("pre_reset", 3, 4'd4, 1'b0);
        bus.compare_in = 24'd0;
        test_period("pre_reset", 3, 4'd5, 1'b0);
        test_period("pre_reset", 5, 4'd6, 1'b0);
        run_cycles(4);
        n_vec++;
        if ({bus.digit, bus.cnt_lsb} !== {4'd6, 8'd4}) begin
            n_err++;
            $display("[TB] FAIL pre_reset_state: got %b, expected %b", {bus.digit, bus.cnt_lsb}, {4'd6, 8'd4});
        end
        bus.compare_in = 24'd3;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({bus.tick, bus.wrap, bus.digit, bus.cnt_lsb} !== 14'd0) begin
            n_err++;
            $display("[TB] FAIL async_reset: got %b, expected 0", {bus.tick, bus.wrap, bus.digit, bus.cnt_lsb});
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_period("post_reset_default", 5, 4'd1, 1'b0);
        test_period("post_reset_new", 3, 4'd2, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_default_period();
        test_compare_change();
        test_every_cycle();
        bus.compare_in = 24'd0;
        test_period("cmp_restore", 1, 4'd5, 1'b0);
        test_pause(1'b0, 4'd5);
        test_pause(1'b1, 4'd6);
        test_clear_on_term();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
